// File: rtl/lvds_rx_init_seq.sv
// LVDS receiver bring-up sequencer. It orders the PLL and per-channel resets and
// handles lock timeouts, bounded retries, channel masking and recovery from lock loss.
module lvds_rx_init_seq #(
  parameter int unsigned NUM_CH             = 4,
  parameter int unsigned RESET_PULSE_CYCLES = 4,
  parameter int unsigned STABLE_CYCLES      = 10,
  parameter int unsigned PLL_TIMEOUT        = 4096,
  parameter int unsigned DPA_TIMEOUT        = 4096,
  parameter int unsigned MAX_RETRIES        = 3,
  localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              user_mode,
  input  logic              restart,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              rx_locked,
  input  logic [NUM_CH-1:0] rx_dpa_locked,
  output logic              pll_areset,
  output logic [NUM_CH-1:0] rx_reset,
  output logic [NUM_CH-1:0] rx_fifo_reset,
  output logic [NUM_CH-1:0] rx_cda_reset,
  output logic              init_done,
  output logic              init_error,
  output logic [NUM_CH-1:0] ch_ready,
  output logic [RW-1:0]     retry_count
);

  localparam int unsigned CNT_MAX = (RESET_PULSE_CYCLES > STABLE_CYCLES) ? RESET_PULSE_CYCLES : STABLE_CYCLES;
  localparam int unsigned TMR_MAX = (PLL_TIMEOUT > DPA_TIMEOUT) ? PLL_TIMEOUT : DPA_TIMEOUT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ASSERT, S_WAIT_PLL, S_PLL_STABLE, S_WAIT_DPA,
    S_FIFO_RESET, S_CDA_RESET, S_DONE, S_RETRY, S_ERROR
  } state_t;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [TW-1:0]     r_tmr, w_tmr_nxt;
  logic [RW-1:0]     r_retry, w_retry_nxt;
  logic [NUM_CH-1:0] r_en_q, w_en_nxt;
  logic [1:0]        r_lock_sync;
  logic [NUM_CH-1:0] r_dpa_s1, r_dpa_s2;
  logic              w_locked, w_dpa_ok;

  logic              w_pll, w_done, w_err;
  logic [NUM_CH-1:0] w_rx, w_fifo, w_cda, w_ready;

  assign w_locked = r_lock_sync[1];
  assign w_dpa_ok = ((r_dpa_s2 & r_en_q) == r_en_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_sync <= '0;
      r_dpa_s1    <= '0;
      r_dpa_s2    <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[0], rx_locked};
      r_dpa_s1    <= rx_dpa_locked;
      r_dpa_s2    <= r_dpa_s1;
    end
  end

  // One timer serves both lock waits: it is cleared on entry to WAIT_PLL_LOCK and again
  // on entry to WAIT_DPA_LOCK, and keeps running across PLL_STABLE -> WAIT_PLL_LOCK.
  always_comb begin
    w_next      = r_state;
    w_cnt_nxt   = r_cnt;
    w_tmr_nxt   = r_tmr;
    w_retry_nxt = r_retry;
    w_en_nxt    = r_en_q;
    if (!user_mode) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_retry_nxt = '0;
          w_next      = S_ASSERT;
        end
        S_ASSERT: begin
          if (r_cnt == CW'(RESET_PULSE_CYCLES - 1)) begin
            w_next    = S_WAIT_PLL;
            w_tmr_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_WAIT_PLL: begin
          if (r_tmr == TW'(PLL_TIMEOUT - 1)) begin
            w_next = S_RETRY;
          end else begin
            w_tmr_nxt = r_tmr + TW'(1);
            if (w_locked) begin
              w_next    = S_PLL_STABLE;
              w_cnt_nxt = '0;
            end
          end
        end
        S_PLL_STABLE: begin
          if (r_tmr == TW'(PLL_TIMEOUT - 1)) begin
            w_next = S_RETRY;
          end else begin
            w_tmr_nxt = r_tmr + TW'(1);
            if (!w_locked) begin
              w_next = S_WAIT_PLL;
            end else if (r_cnt == CW'(STABLE_CYCLES - 1)) begin
              w_next    = S_WAIT_DPA;
              w_tmr_nxt = '0;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end
        end
        S_WAIT_DPA: begin
          if (!w_locked)                            w_next = S_RETRY;
          else if (w_dpa_ok)                        w_next = S_FIFO_RESET;
          else if (r_tmr == TW'(DPA_TIMEOUT - 1))   w_next = S_RETRY;
          else                                      w_tmr_nxt = r_tmr + TW'(1);
        end
        S_FIFO_RESET: w_next = w_locked ? S_CDA_RESET : S_RETRY;
        S_CDA_RESET:  w_next = w_locked ? S_DONE : S_RETRY;
        S_DONE: begin
          if (!w_locked) begin
            w_next = S_RETRY;
          end else if (restart) begin
            w_next      = S_ASSERT;
            w_retry_nxt = '0;
          end
        end
        S_RETRY: begin
          if (r_retry == RW'(MAX_RETRIES)) begin
            w_next = S_ERROR;
          end else begin
            w_next      = S_ASSERT;
            w_retry_nxt = r_retry + RW'(1);
          end
        end
        S_ERROR: begin
          if (restart) begin
            w_next      = S_ASSERT;
            w_retry_nxt = '0;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
    if (w_next == S_ASSERT && r_state != S_ASSERT) begin
      w_cnt_nxt = '0;
      w_en_nxt  = ch_enable;
    end
  end

  // Outputs are decoded from the next state and registered, so they change together
  // with the state register and never glitch.
  always_comb begin
    w_pll   = 1'b0;
    w_rx    = ~w_en_nxt;
    w_fifo  = '0;
    w_cda   = '0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    w_ready = '0;
    case (w_next)
      S_IDLE, S_ASSERT, S_RETRY: begin
        w_pll = 1'b1;
        w_rx  = '1;
      end
      S_ERROR: begin
        w_pll = 1'b1;
        w_rx  = '1;
        w_err = 1'b1;
      end
      S_WAIT_PLL, S_PLL_STABLE: w_rx = '1;
      S_FIFO_RESET: w_fifo = w_en_nxt;
      S_CDA_RESET:  w_cda  = w_en_nxt;
      S_DONE: begin
        w_done  = 1'b1;
        w_ready = w_en_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_tmr         <= '0;
      r_retry       <= '0;
      r_en_q        <= '0;
      pll_areset    <= 1'b1;
      rx_reset      <= '1;
      rx_fifo_reset <= '0;
      rx_cda_reset  <= '0;
      init_done     <= 1'b0;
      init_error    <= 1'b0;
      ch_ready      <= '0;
    end else begin
      r_state       <= w_next;
      r_cnt         <= w_cnt_nxt;
      r_tmr         <= w_tmr_nxt;
      r_retry       <= w_retry_nxt;
      r_en_q        <= w_en_nxt;
      pll_areset    <= w_pll;
      rx_reset      <= w_rx;
      rx_fifo_reset <= w_fifo;
      rx_cda_reset  <= w_cda;
      init_done     <= w_done;
      init_error    <= w_err;
      ch_ready      <= w_ready;
    end
  end

  assign retry_count = r_retry;

endmodule

// File: tb/tb_lvds_rx_init_seq.sv
// Bench for lvds_rx_init_seq: directed vector table, hand-written corner sequences and
// randomised stimulus compared every cycle against a phase-level reference model.
module tb_lvds_rx_init_seq;
  localparam int unsigned NCH  = 4;
  localparam int unsigned RPC  = 4;
  localparam int unsigned STB  = 10;
  localparam int unsigned PTO  = 64;
  localparam int unsigned DTO  = 64;
  localparam int unsigned MAXR = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           user_mode = 1'b0;
  logic           restart = 1'b0;
  logic [NCH-1:0] ch_enable = '0;
  logic           rx_locked = 1'b0;
  logic [NCH-1:0] rx_dpa_locked = '0;
  logic           pll_areset, init_done, init_error;
  logic [NCH-1:0] rx_reset, rx_fifo_reset, rx_cda_reset, ch_ready;
  logic [1:0]     retry_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lvds_rx_init_seq #(
    .NUM_CH(NCH), .RESET_PULSE_CYCLES(RPC), .STABLE_CYCLES(STB),
    .PLL_TIMEOUT(PTO), .DPA_TIMEOUT(DTO), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .user_mode(user_mode), .restart(restart),
    .ch_enable(ch_enable), .rx_locked(rx_locked), .rx_dpa_locked(rx_dpa_locked),
    .pll_areset(pll_areset), .rx_reset(rx_reset), .rx_fifo_reset(rx_fifo_reset),
    .rx_cda_reset(rx_cda_reset), .init_done(init_done), .init_error(init_error),
    .ch_ready(ch_ready), .retry_count(retry_count)
  );

  logic [20:0] act;
  assign act = {pll_areset, rx_reset, rx_fifo_reset, rx_cda_reset, init_done, init_error, ch_ready, retry_count};

  function automatic logic [20:0] mk(input logic p, input logic [3:0] rx, input logic [3:0] fi,
                                     input logic [3:0] cd, input logic d, input logic e,
                                     input logic [3:0] rd, input logic [1:0] rc);
    return {p, rx, fi, cd, d, e, rd, rc};
  endfunction

  // Reference model: phases of the bring-up procedure with elapsed-cycle bookkeeping.
  typedef enum {M_IDLE, M_RST, M_PLL_WAIT, M_PLL_HOLD, M_DPA, M_FIFO, M_CDA, M_UP, M_RETRY, M_ERR} mphase_t;
  mphase_t  mp = M_IDLE;
  int       m_age = 0, m_pll_el = 0, m_run = 0, m_rc = 0;
  logic [3:0] m_en = '0;
  logic     lk_hist [2] = '{1'b0, 1'b0};
  logic [3:0] dp_hist [2] = '{4'h0, 4'h0};
  logic     m_lk;
  logic [3:0] m_dp;

  task automatic m_enter_rst();
    mp = M_RST; m_age = 0; m_en = ch_enable;
  endtask

  task automatic m_step();
    m_lk = lk_hist[1]; m_dp = dp_hist[1];
    lk_hist[1] = lk_hist[0]; lk_hist[0] = rx_locked;
    dp_hist[1] = dp_hist[0]; dp_hist[0] = rx_dpa_locked;
    if (!user_mode) begin
      mp = M_IDLE;
    end else begin
      case (mp)
        M_IDLE: begin m_rc = 0; m_enter_rst(); end
        M_RST: begin
          m_age++;
          if (m_age == int'(RPC)) begin mp = M_PLL_WAIT; m_pll_el = 0; end
        end
        M_PLL_WAIT, M_PLL_HOLD: begin
          m_pll_el++;
          if (m_pll_el == int'(PTO)) mp = M_RETRY;
          else if (mp == M_PLL_WAIT) begin
            if (m_lk) begin mp = M_PLL_HOLD; m_run = 0; end
          end else if (!m_lk) mp = M_PLL_WAIT;
          else begin
            m_run++;
            if (m_run == int'(STB)) begin mp = M_DPA; m_age = 0; end
          end
        end
        M_DPA: begin
          if (!m_lk) mp = M_RETRY;
          else if ((m_dp & m_en) == m_en) mp = M_FIFO;
          else begin
            m_age++;
            if (m_age == int'(DTO)) mp = M_RETRY;
          end
        end
        M_FIFO: mp = m_lk ? M_CDA : M_RETRY;
        M_CDA:  mp = m_lk ? M_UP : M_RETRY;
        M_UP: begin
          if (!m_lk) mp = M_RETRY;
          else if (restart) begin m_rc = 0; m_enter_rst(); end
        end
        M_RETRY: begin
          if (m_rc == int'(MAXR)) mp = M_ERR;
          else begin m_rc++; m_enter_rst(); end
        end
        M_ERR: if (restart) begin m_rc = 0; m_enter_rst(); end
        default: mp = M_IDLE;
      endcase
    end
  endtask

  function automatic logic [20:0] m_out();
    logic in_rst, pll_phase;
    pll_phase = (mp == M_IDLE) || (mp == M_RST) || (mp == M_RETRY) || (mp == M_ERR);
    in_rst    = pll_phase || (mp == M_PLL_WAIT) || (mp == M_PLL_HOLD);
    return mk(pll_phase, in_rst ? 4'hF : ~m_en,
              (mp == M_FIFO) ? m_en : 4'h0, (mp == M_CDA) ? m_en : 4'h0,
              mp == M_UP, mp == M_ERR, (mp == M_UP) ? m_en : 4'h0, 2'(m_rc));
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mp = M_IDLE; m_rc = 0; m_en = '0;
      lk_hist = '{1'b0, 1'b0}; dp_hist = '{4'h0, 4'h0};
    end else begin
      m_step();
    end
  end

  initial forever begin
    @(negedge clk);
    n_tests++;
    if (act !== m_out()) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t act=%h exp=%h", $time, act, m_out());
    end
  end

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", name, a, e);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic       um;
    logic       rs;
    logic [3:0] en;
    logic       lk;
    logic [3:0] dpa;
    int         n;
    logic [20:0] exp;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int seq, fifo_cyc, cda_cyc;
    logic bad_rx, bad_pulse;
    logic [1:0] last_rc;

    tbl[0]  = '{1'b0, 1'b0, 4'hF, 1'b0, 4'hF, 3,  mk(1, 4'hF, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b1, 1'b0, 4'hF, 1'b0, 4'hF, 4,  mk(1, 4'hF, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{1'b1, 1'b0, 4'hF, 1'b0, 4'hF, 1,  mk(0, 4'hF, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{1'b1, 1'b1, 4'hF, 1'b1, 4'hF, 12, mk(0, 4'hF, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{1'b1, 1'b0, 4'hF, 1'b1, 4'hF, 1,  mk(0, 4'h0, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{1'b1, 1'b0, 4'hF, 1'b1, 4'hF, 1,  mk(0, 4'h0, 4'hF, 0, 0, 0, 0, 0)};
    tbl[6]  = '{1'b1, 1'b0, 4'hF, 1'b1, 4'hF, 1,  mk(0, 4'h0, 0, 4'hF, 0, 0, 0, 0)};
    tbl[7]  = '{1'b1, 1'b0, 4'hF, 1'b1, 4'hF, 1,  mk(0, 4'h0, 0, 0, 1, 0, 4'hF, 0)};
    tbl[8]  = '{1'b1, 1'b0, 4'hF, 1'b1, 4'hF, 5,  mk(0, 4'h0, 0, 0, 1, 0, 4'hF, 0)};
    tbl[9]  = '{1'b1, 1'b0, 4'hF, 1'b0, 4'hF, 2,  mk(0, 4'h0, 0, 0, 1, 0, 4'hF, 0)};
    tbl[10] = '{1'b1, 1'b0, 4'hF, 1'b0, 4'hF, 1,  mk(1, 4'hF, 0, 0, 0, 0, 0, 0)};
    tbl[11] = '{1'b1, 1'b0, 4'hF, 1'b0, 4'hF, 1,  mk(1, 4'hF, 0, 0, 0, 0, 0, 1)};
    tbl[12] = '{1'b0, 1'b0, 4'hF, 1'b0, 4'hF, 1,  mk(1, 4'hF, 0, 0, 0, 0, 0, 1)};
    tbl[13] = '{1'b0, 1'b0, 4'hF, 1'b0, 4'hF, 2,  mk(1, 4'hF, 0, 0, 0, 0, 0, 1)};
    tbl[14] = '{1'b1, 1'b0, 4'hF, 1'b0, 4'hF, 1,  mk(1, 4'hF, 0, 0, 0, 0, 0, 0)};
    tbl[15] = '{1'b0, 1'b0, 4'hF, 1'b0, 4'hF, 1,  mk(1, 4'hF, 0, 0, 0, 0, 0, 0)};

    hold(2);
    chk("reset_state", 32'(act), 32'(mk(1, 4'hF, 0, 0, 0, 0, 0, 0)));
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      user_mode = tbl[i].um; restart = tbl[i].rs; ch_enable = tbl[i].en;
      rx_locked = tbl[i].lk; rx_dpa_locked = tbl[i].dpa;
      hold(tbl[i].n);
      chk($sformatf("tbl%0d", i), 32'(act), 32'(tbl[i].exp));
    end
    restart = 1'b0;

    // Masked channels: only ch0/ch2 enabled and locked.
    ch_enable = 4'b0101; rx_dpa_locked = 4'b0101; rx_locked = 1'b1; user_mode = 1'b1;
    bad_rx = 1'b0; bad_pulse = 1'b0; fifo_cyc = 0; cda_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      hold(1);
      if (!rx_reset[1] || !rx_reset[3]) bad_rx = 1'b1;
      if (rx_fifo_reset[1] || rx_fifo_reset[3] || rx_cda_reset[1] || rx_cda_reset[3]) bad_pulse = 1'b1;
      if (rx_fifo_reset != 4'h0) fifo_cyc++;
      if (rx_cda_reset != 4'h0) cda_cyc++;
      if (init_done) break;
    end
    chk("mask_done", 32'(init_done), 32'd1);
    chk("mask_ready", 32'(ch_ready), 32'h5);
    chk("mask_rx", 32'(rx_reset), 32'hA);
    chk("mask_noleak", 32'({bad_rx, bad_pulse}), 32'd0);
    chk("mask_pulses", 32'(fifo_cyc * 10 + cda_cyc), 32'd11);

    // Flaky PLL: lock drops once the stable count has reached 7.
    user_mode = 1'b0; hold(1);
    user_mode = 1'b1; ch_enable = 4'hF; rx_dpa_locked = 4'hF; rx_locked = 1'b0;
    hold(5);
    chk("flaky_pll_rel", 32'(pll_areset), 32'd0);
    rx_locked = 1'b1; hold(8);
    rx_locked = 1'b0; hold(1);
    rx_locked = 1'b1; hold(12);
    chk("flaky_rx_held", 32'(rx_reset), 32'hF);
    hold(1);
    chk("flaky_rx_rel", 32'({rx_reset, retry_count}), 32'h0);
    hold(3);
    chk("flaky_done", 32'({init_done, retry_count}), 32'h4);

    // PLL timeout with lock held low: three retries then ERROR.
    user_mode = 1'b0; rx_locked = 1'b0; hold(1);
    user_mode = 1'b1;
    seq = 0; last_rc = 2'd0;
    for (int i = 0; i < 276; i++) begin
      hold(1);
      if (retry_count != last_rc) begin
        seq = seq * 10 + int'(retry_count);
        last_rc = retry_count;
      end
    end
    chk("to_seq", 32'(seq), 32'd123);
    chk("to_before_err", 32'({init_error, pll_areset}), 32'h1);
    hold(1);
    chk("to_error", 32'(act), 32'(mk(1, 4'hF, 0, 0, 0, 1, 0, 3)));
    hold(5);
    chk("to_error_hold", 32'(init_error), 32'd1);
    restart = 1'b1; hold(1);
    restart = 1'b0;
    chk("to_restart", 32'(act), 32'(mk(1, 4'hF, 0, 0, 0, 0, 0, 0)));

    // Abort in WAIT_DPA_LOCK with a coincident restart.
    rx_locked = 1'b1; rx_dpa_locked = 4'h0;
    for (int i = 0; i < 100; i++) begin
      hold(1);
      if (rx_reset != 4'hF) break;
    end
    chk("abort_reach_dpa", 32'({pll_areset, rx_reset}), 32'h0);
    user_mode = 1'b0; restart = 1'b1; hold(1);
    chk("abort_idle", 32'(act), 32'(mk(1, 4'hF, 0, 0, 0, 0, 0, 0)));
    restart = 1'b0; hold(2);
    chk("abort_stay", 32'({pll_areset, rx_reset}), 32'h1F);

    // Asynchronous reset between clock edges.
    user_mode = 1'b1; rx_dpa_locked = 4'hF;
    for (int i = 0; i < 40; i++) begin
      hold(1);
      if (init_done) break;
    end
    chk("async_pre_done", 32'(init_done), 32'd1);
    rst_n = 1'b0; #2;
    chk("async_reset", 32'(act), 32'(mk(1, 4'hF, 0, 0, 0, 0, 0, 0)));
    #1 rst_n = 1'b1;
    hold(1);

    // Randomised stimulus against the reference model.
    for (int i = 0; i < 5000; i++) begin
      rst_n     = ($urandom_range(0, 1499) != 0);
      user_mode = ($urandom_range(0, 199) != 0);
      restart   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 49) == 0) ch_enable = 4'($urandom);
      if ($urandom_range(0, 39) == 0) rx_locked = ~rx_locked;
      for (int unsigned b = 0; b < NCH; b++)
        if ($urandom_range(0, 7) == 0) rx_dpa_locked[b] = ~rx_dpa_locked[b];
      hold(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
